// File: rtl/mux_ctrl_pkg.sv
// Shared types and select encodings for the 2:1 mux controller.
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_X = 2'd1,
        OWN_Y = 2'd2
    } state_t;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

endpackage

// File: rtl/mux2_out_reg.sv
// One-entry valid/ready output register holding the beat taken through the mux.
module mux2_out_reg
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             d_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             space_c
);

    // Entry can take a new beat when empty or being drained this cycle.
    assign space_c = !d_valid || d_ready;

    // Load overrides drain so accept+drain keeps the entry full with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= '0;
            d_valid <= 1'b0;
        end else if (load) begin
            d_out   <= data_in;
            d_valid <= 1'b1;
        end else if (d_ready) begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_sel_ctrl.sv
// Round-robin, burst-limited arbiter driving the 2:1 mux select, with a
// registered output stage for the mux result.
module mux2_rr_sel_ctrl
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             X_VALID,
    output logic             X_READY,
    input  logic             Y_VALID,
    output logic             Y_READY,
    output logic             S,
    input  logic [WIDTH-1:0] O_IN,
    output logic [WIDTH-1:0] D_OUT,
    output logic             D_VALID,
    input  logic             D_READY
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             space_c;
    logic             owner_valid_c;
    logic             accept_c;

    // Ready is granted only to the owner and only when the output entry has room.
    assign X_READY       = (state_q == OWN_X) && space_c;
    assign Y_READY       = (state_q == OWN_Y) && space_c;
    assign owner_valid_c = (state_q == OWN_X) ? X_VALID : Y_VALID;
    assign accept_c      = (X_VALID && X_READY) || (Y_VALID && Y_READY);
    assign S             = sel_q;

    // Arbiter state, select, last owner and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_X;
            last_q  <= SEL_Y;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and release while owned.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (X_VALID && (!Y_VALID || last_q == SEL_Y)) begin
                    state_d = OWN_X;
                    sel_d   = SEL_X;
                end else if (Y_VALID) begin
                    state_d = OWN_Y;
                    sel_d   = SEL_Y;
                end
            end
            OWN_X, OWN_Y: begin
                if ((accept_c && cnt_q == LAST_BEAT) || (!accept_c && !owner_valid_c)) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                    cnt_d   = '0;
                end else if (accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    mux2_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_c),
        .data_in (O_IN),
        .d_ready (D_READY),
        .d_out   (D_OUT),
        .d_valid (D_VALID),
        .space_c (space_c)
    );

endmodule

// File: tb/tb_mux2_rr_sel_ctrl.sv
// Bench for mux2_rr_sel_ctrl: per-cycle vector tables plus a data scoreboard.
module tb_mux2_rr_sel_ctrl;

    typedef struct {
        logic       xv;
        logic       yv;
        logic       dr;
        logic [1:0] o;
        logic       s;
        logic       xr;
        logic       yr;
        logic       dv;
    } vec_t;

    logic       clk;
    logic       a_rst_n, a_xv, a_xr, a_yv, a_yr, a_s, a_dv, a_dr;
    logic [1:0] a_o, a_dout;
    logic       b_rst_n, b_xv, b_xr, b_yv, b_yr, b_s, b_dv, b_dr;
    logic [1:0] b_o, b_dout;

    vec_t       vq[$];
    vec_t       vb[$];
    logic [1:0] sb_a[$];
    logic [1:0] sb_b[$];
    int         checks = 0;
    int         errors = 0;

    localparam logic [1:0] X_DATA = 2'b01;
    localparam logic [1:0] Y_DATA = 2'b10;

    mux2_rr_sel_ctrl #(.WIDTH(2), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .X_VALID(a_xv), .X_READY(a_xr), .Y_VALID(a_yv), .Y_READY(a_yr),
        .S(a_s), .O_IN(a_o), .D_OUT(a_dout), .D_VALID(a_dv), .D_READY(a_dr)
    );

    mux2_rr_sel_ctrl #(.WIDTH(2), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .X_VALID(b_xv), .X_READY(b_xr), .Y_VALID(b_yv), .Y_READY(b_yr),
        .S(b_s), .O_IN(b_o), .D_OUT(b_dout), .D_VALID(b_dv), .D_READY(b_dr)
    );

    // Model of the 2:1 mux in front of instance B.
    assign b_o = b_s ? Y_DATA : X_DATA;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic xv, input logic yv, input logic dr, input logic [1:0] o,
                                input logic s, input logic xr, input logic yr, input logic dv);
        vec_t v;
        v.xv = xv; v.yv = yv; v.dr = dr; v.o = o;
        v.s = s; v.xr = xr; v.yr = yr; v.dv = dv;
        return v;
    endfunction

    initial begin
        //           xv   yv   dr   o      s    xr   yr   dv
        // X alone: four beats, then release
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd0, 1'b0,1'b1,1'b0,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd1, 1'b0,1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd2, 1'b0,1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd3, 1'b0,1'b1,1'b0,1'b1));
        // both valid: Y wins after X, IDLE gap, then X
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd3, 1'b1,1'b0,1'b1,1'b0));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd2, 1'b1,1'b0,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd1, 1'b1,1'b0,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd1, 1'b0,1'b1,1'b0,1'b0));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd2, 1'b0,1'b1,1'b0,1'b1));
        // downstream stall for 3 cycles holding 2'b10
        vq.push_back(mk(1'b1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b0,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd3, 1'b0,1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b1,1'b0,1'b1));
        // Y owns, drops valid after two beats; X then gets a fresh burst of four
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd1, 1'b1,1'b0,1'b1,1'b0));
        vq.push_back(mk(1'b1,1'b1,1'b1,2'd2, 1'b1,1'b0,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd0, 1'b1,1'b0,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd0, 1'b1,1'b0,1'b0,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd2, 1'b0,1'b1,1'b0,1'b0));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd3, 1'b0,1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd0, 1'b0,1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,2'd1, 1'b0,1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b0,1'b0,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vq.push_back(mk(1'b0,1'b0,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b0));
        // Y alone, leaves D_VALID=1 and S=1 for the reset test
        vq.push_back(mk(1'b0,1'b1,1'b1,2'd3, 1'b0,1'b0,1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b1,1'b1,2'd3, 1'b1,1'b0,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b1,1'b1,2'd1, 1'b1,1'b0,1'b1,1'b1));

        // BURST_LEN=1 with both valid: single beats alternating X, Y
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b0));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b1,1'b0,1'b0));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0,1'b1,1'b0));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0,1'b0,1'b1));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b1,1'b0,1'b0));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b0,1'b0,1'b0,1'b1));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0,1'b1,1'b0));
        vb.push_back(mk(1'b1,1'b1,1'b1,2'd0, 1'b1,1'b0,1'b0,1'b1));

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_xv = 1'b0; a_yv = 1'b0; a_dr = 1'b0; a_o = 2'd0;
        b_xv = 1'b0; b_yv = 1'b0; b_dr = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset S", 32'(a_s), 32'd0);
        check("reset X_READY", 32'(a_xr), 32'd0);
        check("reset Y_READY", 32'(a_yr), 32'd0);
        check("reset D_VALID", 32'(a_dv), 32'd0);
        check("reset D_OUT", 32'(a_dout), 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1'b1;

        // instance A: table-driven cycles
        for (int i = 0; i < vq.size(); i++) begin
            a_xv = vq[i].xv; a_yv = vq[i].yv; a_dr = vq[i].dr; a_o = vq[i].o;
            @(negedge clk);
            check($sformatf("a_r%0d S", i), 32'(a_s), 32'(vq[i].s));
            check($sformatf("a_r%0d X_READY", i), 32'(a_xr), 32'(vq[i].xr));
            check($sformatf("a_r%0d Y_READY", i), 32'(a_yr), 32'(vq[i].yr));
            check($sformatf("a_r%0d D_VALID", i), 32'(a_dv), 32'(vq[i].dv));
            if (vq[i].dv) begin
                if (sb_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_r%0d scoreboard empty, D_OUT=%0h", i, a_dout);
                end else if (vq[i].dr) begin
                    check($sformatf("a_r%0d D_OUT", i), 32'(a_dout), 32'(sb_a.pop_front()));
                end else begin
                    check($sformatf("a_r%0d D_OUT hold", i), 32'(a_dout), 32'(sb_a[0]));
                end
            end
            if ((vq[i].xv && vq[i].xr) || (vq[i].yv && vq[i].yr)) sb_a.push_back(vq[i].o);
            @(posedge clk); #1;
        end

        // asynchronous reset mid-burst while Y owns and D_VALID=1
        #2 a_rst_n = 1'b0;
        #1;
        check("async rst D_VALID", 32'(a_dv), 32'd0);
        check("async rst D_OUT", 32'(a_dout), 32'd0);
        check("async rst S", 32'(a_s), 32'd0);
        check("async rst X_READY", 32'(a_xr), 32'd0);
        check("async rst Y_READY", 32'(a_yr), 32'd0);
        sb_a.delete();
        a_xv = 1'b1; a_yv = 1'b1; a_dr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in rst X_READY", 32'(a_xr), 32'd0);
        check("in rst Y_READY", 32'(a_yr), 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        @(negedge clk);
        check("post rst idle X_READY", 32'(a_xr), 32'd0);
        check("post rst idle Y_READY", 32'(a_yr), 32'd0);
        check("post rst idle D_VALID", 32'(a_dv), 32'd0);
        @(negedge clk);
        check("post rst tie S", 32'(a_s), 32'd0);
        check("post rst tie X_READY", 32'(a_xr), 32'd1);
        check("post rst tie Y_READY", 32'(a_yr), 32'd0);

        // instance B: BURST_LEN=1 alternation
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        for (int i = 0; i < vb.size(); i++) begin
            b_xv = vb[i].xv; b_yv = vb[i].yv; b_dr = vb[i].dr;
            @(negedge clk);
            check($sformatf("b_c%0d S", i), 32'(b_s), 32'(vb[i].s));
            check($sformatf("b_c%0d X_READY", i), 32'(b_xr), 32'(vb[i].xr));
            check($sformatf("b_c%0d Y_READY", i), 32'(b_yr), 32'(vb[i].yr));
            check($sformatf("b_c%0d D_VALID", i), 32'(b_dv), 32'(vb[i].dv));
            if (vb[i].dv) begin
                if (sb_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_c%0d scoreboard empty, D_OUT=%0h", i, b_dout);
                end else begin
                    check($sformatf("b_c%0d D_OUT", i), 32'(b_dout), 32'(sb_b.pop_front()));
                end
            end
            if (vb[i].xv && vb[i].xr) sb_b.push_back(X_DATA);
            if (vb[i].yv && vb[i].yr) sb_b.push_back(Y_DATA);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
